// File: rtl/tennis_pkg.sv
// Shared types and constants for the tennis rally logic.
package tennis_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SERVE,
      MOVE,
      POINT
   } state_t;

   // Ball direction: 1 travels toward player one (MSB end), 0 toward player two.
   localparam logic DIR_TO_ONE = 1'b1;
   localparam logic DIR_TO_TWO = 1'b0;

   localparam logic PLAYER_ONE = 1'b0;
   localparam logic PLAYER_TWO = 1'b1;

   localparam int unsigned RALLY_W = 8;

endpackage

// File: rtl/step_timer.sv
// Variable-period tick generator: counts while enabled and pulses tick on the
// last cycle of each period. clear has priority and suppresses the tick.
module step_timer #(
   parameter int unsigned PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clear,
   input  logic [PW-1:0] period,
   output logic          tick
);

   logic [PW-1:0] cnt_q, cnt_d;

   // Tick decode and next count value.
   always_comb begin
      tick  = en && !clear && (cnt_q >= period - PW'(1));
      cnt_d = cnt_q;
      if (clear || tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + PW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/rally_engine.sv
// Two-player rally engine: serve, ball travel, hit windows, speed-up on
// return, miss detection, point pulses and serve alternation.
// Optional build macro EARLY_SWING_FAULT_EN: a press by the receiving player
// outside the hit window awards the point to the opponent.
module rally_engine
   import tennis_pkg::*;
#(
   parameter int unsigned COURT_W      = 16,
   parameter int unsigned HIT_WIN      = 3,
   parameter int unsigned BASE_PERIOD  = 25000000,
   parameter int unsigned MIN_PERIOD   = 5000000,
   parameter int unsigned SPEEDUP_STEP = 2000000,
   parameter int unsigned POINT_HOLD   = 50000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               hit_one,
   input  logic               hit_two,
   output logic [COURT_W-1:0] pos,
   output logic               hittable_one,
   output logic               hittable_two,
   output logic               point_one,
   output logic               point_two,
   output logic [RALLY_W-1:0] rally_cnt,
   output logic               busy
);

   localparam int unsigned IW = $clog2(COURT_W);
   localparam int unsigned PW = $clog2(BASE_PERIOD + 1);
   localparam int unsigned HW = $clog2(POINT_HOLD + 1);
   localparam logic [IW-1:0] IDX_ONE = IW'(COURT_W - 1);
   localparam logic [IW-1:0] IDX_TWO = '0;

   state_t             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic               dir_q, dir_d;
   logic               server_q, server_d;
   logic [PW-1:0]      period_q, period_d;
   logic [RALLY_W-1:0] rally_q, rally_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic               point_one_q, point_one_d;
   logic               point_two_q, point_two_d;

   logic in_move, ret, fault, tick, at_end, timer_clear;

   // Hit windows and press classification, from registered state only.
   always_comb begin
      in_move = (state_q == MOVE);
      hittable_one = ((state_q == SERVE) && (server_q == PLAYER_ONE)) ||
                     (in_move && (dir_q == DIR_TO_ONE) && (idx_q >= IW'(COURT_W - HIT_WIN)));
      hittable_two = ((state_q == SERVE) && (server_q == PLAYER_TWO)) ||
                     (in_move && (dir_q == DIR_TO_TWO) && (idx_q <= IW'(HIT_WIN - 1)));
      ret    = in_move && ((hit_one && hittable_one) || (hit_two && hittable_two));
      at_end = (dir_q == DIR_TO_ONE) ? (idx_q == IDX_ONE) : (idx_q == IDX_TWO);
`ifdef EARLY_SWING_FAULT_EN
      fault  = in_move && (((dir_q == DIR_TO_ONE) && hit_one && !hittable_one) ||
                           ((dir_q == DIR_TO_TWO) && hit_two && !hittable_two));
`else
      fault  = 1'b0;
`endif
      timer_clear = !in_move || ret;
   end

   step_timer #(.PW(PW)) u_step_timer (
      .clk    (clk),
      .rst_n  (rst),
      .en     (in_move),
      .clear  (timer_clear),
      .period (period_q),
      .tick   (tick)
   );

   // Rally state machine: next state and register updates.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      dir_d       = dir_q;
      server_d    = server_q;
      period_d    = period_q;
      rally_d     = rally_q;
      hold_d      = hold_q;
      point_one_d = 1'b0;
      point_two_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SERVE;
               idx_d   = (server_q == PLAYER_ONE) ? IDX_ONE : IDX_TWO;
            end
         end
         SERVE: begin
            if ((server_q == PLAYER_ONE) ? hit_one : hit_two) begin
               state_d  = MOVE;
               dir_d    = (server_q == PLAYER_ONE) ? DIR_TO_TWO : DIR_TO_ONE;
               period_d = PW'(BASE_PERIOD);
               rally_d  = '0;
            end
         end
         MOVE: begin
            // The timer suppresses its tick on a return, so a return always
            // beats a same-cycle move or miss.
            if (ret) begin
               dir_d = ~dir_q;
               if (32'(period_q) >= MIN_PERIOD + SPEEDUP_STEP)
                  period_d = period_q - PW'(SPEEDUP_STEP);
               else
                  period_d = PW'(MIN_PERIOD);
               if (rally_q != '1) rally_d = rally_q + RALLY_W'(1);
            end else if ((tick && at_end) || fault) begin
               state_d = POINT;
               hold_d  = '0;
               if (dir_q == DIR_TO_TWO) point_one_d = 1'b1;
               else                     point_two_d = 1'b1;
            end else if (tick) begin
               idx_d = (dir_q == DIR_TO_ONE) ? idx_q + IW'(1) : idx_q - IW'(1);
            end
         end
         POINT: begin
            if (hold_q == HW'(POINT_HOLD - 1)) begin
               state_d  = SERVE;
               server_d = ~server_q;
               idx_d    = (server_q == PLAYER_ONE) ? IDX_TWO : IDX_ONE;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         idx_q       <= IDX_ONE;
         dir_q       <= DIR_TO_TWO;
         server_q    <= PLAYER_ONE;
         period_q    <= PW'(BASE_PERIOD);
         rally_q     <= '0;
         hold_q      <= '0;
         point_one_q <= 1'b0;
         point_two_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dir_q       <= dir_d;
         server_q    <= server_d;
         period_q    <= period_d;
         rally_q     <= rally_d;
         hold_q      <= hold_d;
         point_one_q <= point_one_d;
         point_two_q <= point_two_d;
      end
   end

   // One-hot position and status outputs.
   always_comb begin
      pos        = '0;
      pos[idx_q] = 1'b1;
      point_one  = point_one_q;
      point_two  = point_two_q;
      rally_cnt  = rally_q;
      busy       = (state_q != IDLE);
   end

endmodule

// File: tb/tb_rally_engine.sv
// Directed testbench for rally_engine with a short court timing profile.
module tb_rally_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        hit_one = 1'b0;
   logic        hit_two = 1'b0;
   logic [15:0] pos;
   logic        hittable_one, hittable_two, point_one, point_two, busy;
   logic [7:0]  rally_cnt;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   rally_engine #(
      .COURT_W      (16),
      .HIT_WIN      (3),
      .BASE_PERIOD  (4),
      .MIN_PERIOD   (2),
      .SPEEDUP_STEP (1),
      .POINT_HOLD   (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .hit_one      (hit_one),
      .hit_two      (hit_two),
      .pos          (pos),
      .hittable_one (hittable_one),
      .hittable_two (hittable_two),
      .point_one    (point_one),
      .point_two    (point_two),
      .rally_cnt    (rally_cnt),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n clocks; outputs are sampled 1 time unit after each edge.
   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic one, input logic two);
      hit_one = one;
      hit_two = two;
      step(1);
      hit_one = 1'b0;
      hit_two = 1'b0;
   endtask

   initial begin
      // Reset state
      step(2);
      check("rst_pos", pos, 16'h8000);
      check("rst_busy", busy, 0);
      check("rst_rally", rally_cnt, 0);
      check("rst_h1", hittable_one, 0);
      check("rst_h2", hittable_two, 0);
      check("rst_p1", point_one, 0);
      check("rst_p2", point_two, 0);
      rst = 1'b1;
      step(1);

      press(1'b1, 1'b0);
      check("idle_ignore_busy", busy, 0);

      // Serve by player one, ball walks toward two every 4 cycles
      start = 1'b1;
      step(1);
      start = 1'b0;
      check("serve_busy", busy, 1);
      check("serve_pos", pos, 16'h8000);
      check("serve_h1", hittable_one, 1);
      check("serve_h2", hittable_two, 0);
      press(1'b0, 1'b1);
      check("serve_rx_ignored", hittable_one, 1);
      press(1'b1, 1'b0);
      check("move_h1", hittable_one, 0);
      check("move_pos0", pos, 16'h8000);
      step(3);
      check("move_before_tick", pos, 16'h8000);
      step(1);
      check("walk_1", pos, 16'h4000);
      for (int unsigned k = 2; k <= 13; k++) begin
         step(4);
         check("walk", pos, 32'h8000 >> k);
      end

      // Returns and speed-up
      check("win2_h2", hittable_two, 1);
      check("win2_h1", hittable_one, 0);
      press(1'b0, 1'b1);
      check("ret1_rally", rally_cnt, 1);
      check("ret1_pos", pos, 16'h0004);
      check("ret1_h2", hittable_two, 0);
      step(2);
      check("p3_hold", pos, 16'h0004);
      step(1);
      check("p3_move", pos, 16'h0008);
      step(30);
      check("p3_far", pos, 16'h2000);
      check("far_h1", hittable_one, 1);
      press(1'b1, 1'b0);
      check("ret2_rally", rally_cnt, 2);
      step(22);
      check("p2_near", pos, 16'h0004);
      check("p2_h2", hittable_two, 1);
      press(1'b0, 1'b1);
      check("ret3_rally", rally_cnt, 3);
      step(1);
      check("p2_floor_hold", pos, 16'h0004);
      step(1);
      check("p2_floor_move", pos, 16'h0008);
      step(20);
      check("p2_far", pos, 16'h2000);
      press(1'b1, 1'b0);
      check("ret4_rally", rally_cnt, 4);

      // Return coinciding with the end-of-court tick
      step(26);
      check("end_pos", pos, 16'h0001);
      check("end_h2", hittable_two, 1);
      step(1);
      press(1'b1, 1'b1);
      check("tickret_rally", rally_cnt, 5);
      check("tickret_pos", pos, 16'h0001);
      check("tickret_p1", point_one, 0);
      check("tickret_p2", point_two, 0);
      check("tickret_busy", busy, 1);
      step(1);
      check("tickret_hold", pos, 16'h0001);
      step(1);
      check("tickret_move", pos, 16'h0002);

      // Asynchronous reset mid-rally
      rst = 1'b0;
      #1;
      check("mid_rst_pos", pos, 16'h8000);
      check("mid_rst_rally", rally_cnt, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_p1", point_one, 0);
      check("mid_rst_p2", point_two, 0);
      step(2);
      check("mid_rst_p1_later", point_one, 0);
      check("mid_rst_p2_later", point_two, 0);
      rst = 1'b1;
      step(1);

      // Miss at player two's end, point hold, serve passes to two
      start = 1'b1;
      step(1);
      start = 1'b0;
      press(1'b1, 1'b0);
      step(60);
      check("miss_pos", pos, 16'h0001);
      step(3);
      check("miss_pre_p1", point_one, 0);
      step(1);
      check("miss_p1", point_one, 1);
      check("miss_p2", point_two, 0);
      check("miss_pos_frozen", pos, 16'h0001);
      check("point_h2", hittable_two, 0);
      check("point_busy", busy, 1);
      step(1);
      check("miss_p1_once", point_one, 0);
      step(6);
      check("point_still_h2", hittable_two, 0);
      step(1);
      check("serve2_h2", hittable_two, 1);
      check("serve2_h1", hittable_one, 0);
      check("serve2_pos", pos, 16'h0001);
      check("serve2_rally", rally_cnt, 0);
      press(1'b1, 1'b0);
      check("serve2_rx_ignored", hittable_two, 1);
      press(1'b0, 1'b1);
      check("serve2_move_h2", hittable_two, 0);
      step(4);
      check("serve2_walk", pos, 16'h0002);

      // Early swing by the receiver outside the window
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      press(1'b1, 1'b0);
      step(28);
      check("early_pos", pos, 16'h0100);
      press(1'b0, 1'b1);
`ifdef EARLY_SWING_FAULT_EN
      check("early_p1", point_one, 1);
      check("early_pos_frozen", pos, 16'h0100);
      check("early_h2", hittable_two, 0);
      step(1);
      check("early_p1_once", point_one, 0);
`else
      check("early_p1", point_one, 0);
      check("early_p2", point_two, 0);
      step(3);
      check("early_walk", pos, 16'h0080);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
